// File: rtl/qd1_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL/STATUS bit
// positions, FSM state encoding and the effective-length helper.
package qd1_led_seq_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_PERIOD = 4'd1;
  localparam logic [3:0] REG_LEN    = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_TABLE0 = 4'd4;

  localparam int DEPTH = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_LOCK   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Index of the final step: LEN 0 behaves as 1, anything above DEPTH clamps to DEPTH.
  function automatic logic [2:0] last_index(input logic [3:0] len);
    if (len == 4'd0)
      return 3'd0;
    else if (len > 4'd8)
      return 3'd7;
    else
      return 3'(len - 4'd1);
  endfunction

endpackage

// File: rtl/qd1_led_seq_timer.sv
// Step-period down-counter: loads at the start of a step, decrements while waiting,
// and flags the decrement that brings it to zero.
module qd1_led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt <= W'(1));

endmodule

// File: rtl/qd1_led_seq.sv
// LED pattern sequencer with config register file and a fixed-priority direct-write
// arbiter in front of the LED PIO s1 slave.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | stopped; CTRL write with en=1 starts at idx 0
//  ST_ISSUE | first cycle of a step; PIO write of TABLE[idx] unless a direct write wins
//  ST_WAIT  | remaining PERIOD-1 cycles of the step, timer counting down
//  ST_DONE  | one-shot finished; behaves as IDLE, done held until cleared
module qd1_led_seq
  import qd1_led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        dir_valid,
  input  logic [7:0]  dir_data,
  output logic        dir_ready,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  seq_state_e          state;
  logic [3:0]          ctrl;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          len;
  logic                done;
  logic [2:0]          idx;
  logic [7:0]          tbl [DEPTH];

  logic                cfg_wr, wr_ctrl, stop, busy, dir_grant;
  logic                issue_now, step_end, is_last, finish, tc;
  logic [PERIOD_W-1:0] per_m1;
  logic [3:0]          tab_off;
  logic                tab_hit;
  logic                unused_wdata;

  assign cfg_wr    = chipselect & ~write_n;
  assign wr_ctrl   = cfg_wr && (address == REG_CTRL);
  assign stop      = wr_ctrl && !writedata[CTRL_EN];
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign dir_ready = ~(ctrl[CTRL_LOCK] & busy);
  assign dir_grant = dir_valid & dir_ready;

  assign per_m1    = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign is_last   = (idx >= last_index(len));
  assign issue_now = (state == ST_ISSUE) && !dir_grant && !stop;
  // ISSUE is the first cycle of a step, so a one-cycle period ends the step right there
  assign step_end  = !stop && (((state == ST_WAIT) && tc) || (issue_now && (per_m1 == '0)));
  assign finish    = step_end && is_last && !ctrl[CTRL_LOOP];

  assign tab_off = address - REG_TABLE0;
  assign tab_hit = (address >= REG_TABLE0) && !tab_off[3];

  assign pio_address  = 2'b00;
  assign irq          = done & ctrl[CTRL_IRQ_EN];
  assign unused_wdata = ^writedata;

  qd1_led_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (issue_now),
    .load_val (per_m1),
    .dec      (state == ST_WAIT),
    .tc       (tc)
  );

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL:   readdata[3:0]          = ctrl;
      REG_PERIOD: readdata[PERIOD_W-1:0] = period;
      REG_LEN:    readdata[3:0]          = len;
      REG_STATUS: readdata[4:0]          = {idx, done, busy};
      default:    if (tab_hit) readdata[7:0] = tbl[tab_off[2:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_wr && tab_hit) begin
      tbl[tab_off[2:0]] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      ctrl           <= '0;
      period         <= '0;
      len            <= '0;
      done           <= 1'b0;
      idx            <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      if (dir_grant) begin
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_writedata  <= {24'b0, dir_data};
      end else if (issue_now) begin
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_writedata  <= {24'b0, tbl[idx]};
      end

      if (wr_ctrl) ctrl <= writedata[3:0];
      if (cfg_wr && (address == REG_PERIOD)) period <= writedata[PERIOD_W-1:0];
      if (cfg_wr && (address == REG_LEN)) len <= writedata[3:0];
      if (cfg_wr && (address == REG_STATUS) && writedata[STAT_DONE]) done <= 1'b0;
      // completion beats a same-cycle W1C of done
      if (finish) begin
        done          <= 1'b1;
        ctrl[CTRL_EN] <= 1'b0;
      end

      if (stop) begin
        state <= ST_IDLE;
      end else if (step_end) begin
        if (!is_last) begin
          idx   <= idx + 3'd1;
          state <= ST_ISSUE;
        end else if (ctrl[CTRL_LOOP]) begin
          idx   <= '0;
          state <= ST_ISSUE;
        end else begin
          state <= ST_DONE;
        end
      end else if (((state == ST_IDLE) || (state == ST_DONE)) && wr_ctrl) begin
        idx   <= '0;
        state <= ST_ISSUE;
      end else if (issue_now) begin
        state <= ST_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_qd1_led_seq.sv
// Bench for qd1_led_seq: directed config sequences push expected PIO writes (value and
// cycle) into a queue; a monitor pops and compares each PIO write the DUT presents.
module tb_qd1_led_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        dir_valid = 1'b0;
  logic [7:0]  dir_data = '0;
  logic        dir_ready;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        irq;

  qd1_led_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .dir_valid      (dir_valid),
    .dir_data       (dir_data),
    .dir_ready      (dir_ready),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expect_pio(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: every PIO write must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (pio_chipselect === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pio_write: got 0x%0h at cycle %0d want no write",
                 pio_writedata, cyc);
      end else begin
        e = sb.pop_front();
        chk("pio_data", {31'b0, pio_write_n, pio_writedata}, {32'b0, 24'b0, e.d});
        chk("pio_cycle", 64'(cyc), 64'(e.c));
        chk("pio_address", 64'(pio_address), 64'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] want, input string name);
    address = a;
    #1;
    chk(name, 64'(readdata), 64'(want));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  initial begin
    int p;

    // Reset and idle outputs
    address = 4'd3;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_pio_cs", 64'(pio_chipselect), 64'd0);
      chk("rst_pio_write_n", 64'(pio_write_n), 64'd1);
      chk("rst_status", 64'(readdata), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
    end

    // One-shot: three steps of period 3
    wr(4'd4, 32'h01);
    wr(4'd5, 32'h02);
    wr(4'd6, 32'h04);
    wr(4'd1, 32'd3);
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h1);
    p = cyc;
    expect_pio(8'h01, p + 1);
    expect_pio(8'h02, p + 4);
    expect_pio(8'h04, p + 7);
    step(12);
    rd(4'd3, 32'h0A, "oneshot_status_done");
    rd(4'd0, 32'h0, "oneshot_en_cleared");
    chk("oneshot_irq_off", 64'(irq), 64'd0);
    wr(4'd3, 32'h2);
    rd(4'd3, 32'h08, "oneshot_w1c");

    // Loop mode: period 1, LEN 2, stopped by CTRL=0
    wr(4'd2, 32'd2);
    wr(4'd1, 32'd1);
    wr(4'd0, 32'h3);
    p = cyc;
    for (int i = 0; i < 6; i++) expect_pio((i % 2 == 0) ? 8'h01 : 8'h02, p + 1 + i);
    step(6);
    wr(4'd0, 32'h0);
    step(3);
    rd(4'd3, 32'h0, "loop_stopped_status");

    // Arbitration, lock=0: direct write on the ISSUE cycle wins, sequencer follows
    wr(4'd1, 32'd3);
    wr(4'd2, 32'd1);
    wr(4'd0, 32'h1);
    p = cyc;
    dir_valid = 1'b1;
    dir_data  = 8'hAA;
    #1 chk("arb_ready_unlocked", 64'(dir_ready), 64'd1);
    expect_pio(8'hAA, p + 1);
    expect_pio(8'h01, p + 2);
    step(1);
    dir_valid = 1'b0;
    step(6);
    wr(4'd3, 32'h2);

    // Arbitration, lock=1: direct request waits until the sequence leaves busy
    wr(4'd0, 32'h5);
    p = cyc;
    dir_valid = 1'b1;
    dir_data  = 8'h55;
    #1 chk("lock_ready_issue", 64'(dir_ready), 64'd0);
    expect_pio(8'h01, p + 1);
    expect_pio(8'h55, p + 4);
    step(1);
    chk("lock_ready_wait1", 64'(dir_ready), 64'd0);
    step(1);
    chk("lock_ready_wait2", 64'(dir_ready), 64'd0);
    step(1);
    chk("lock_ready_done", 64'(dir_ready), 64'd1);
    step(1);
    dir_valid = 1'b0;
    wr(4'd3, 32'h2);
    wr(4'd0, 32'h0);

    // LEN=0 and PERIOD=0 behave as 1
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd0);
    wr(4'd0, 32'h1);
    p = cyc;
    expect_pio(8'h01, p + 1);
    step(2);
    rd(4'd3, 32'h02, "len0_status");
    wr(4'd3, 32'h2);

    // LEN=12 clamps to 8 steps
    for (int i = 0; i < 8; i++) wr(4'(4 + i), 32'(8'h10 + i));
    wr(4'd2, 32'd12);
    wr(4'd1, 32'd1);
    wr(4'd0, 32'h1);
    p = cyc;
    for (int i = 0; i < 8; i++) expect_pio(8'(8'h10 + i), p + 1 + i);
    step(10);
    rd(4'd3, 32'h1E, "len12_status");
    rd(4'd2, 32'd12, "len12_readback");
    rd(4'd12, 32'h0, "unmapped_12");
    rd(4'd15, 32'h0, "unmapped_15");
    wr(4'd0, 32'h8);
    chk("irq_on_done", 64'(irq), 64'd1);
    wr(4'd3, 32'h2);
    chk("irq_cleared", 64'(irq), 64'd0);
    wr(4'd0, 32'h0);

    // Reset during WAIT aborts the sequence
    wr(4'd1, 32'd10);
    wr(4'd2, 32'd2);
    wr(4'd0, 32'h1);
    p = cyc;
    expect_pio(8'h10, p + 1);
    step(3);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(15);
    rd(4'd3, 32'h0, "midrst_status");
    rd(4'd0, 32'h0, "midrst_ctrl");
    rd(4'd1, 32'h0, "midrst_period");
    rd(4'd2, 32'h0, "midrst_len");
    rd(4'd4, 32'h0, "midrst_table0");
    chk("midrst_pio_data", 64'(pio_writedata), 64'd0);
    chk("midrst_pio_write_n", 64'(pio_write_n), 64'd1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
